// File: rtl/host_ctrl_frontend_pkg.sv
// Shared definitions for the host control front end: FSM encoding,
// control-word bit positions and status-select values.
package host_ctrl_frontend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ctrl_lo: toggle and target sit directly above the address field
  localparam int LO_TOGGLE_OFS = 0;
  localparam int LO_TARGET_OFS = 1;

  localparam int HI_START_BIT = 1;
  localparam int HI_CLR_BIT   = 2;
  localparam int HI_SEL_BIT   = 3;

  localparam logic SEL_COUNT = 1'b0;
  localparam logic SEL_FLAGS = 1'b1;

  localparam logic TGT_CORE = 1'b0;
  localparam logic TGT_ISA  = 1'b1;

endpackage

// File: rtl/host_ctrl_frontend_edge_pulse.sv
// Registers a host control bit and flags a rising (or any) edge against its
// previous registered value. History preloads the live input under reset.
module host_ctrl_frontend_edge_pulse #(
  parameter bit ANY_EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic s1_q;
  logic hist_q;
  logic hist_d;

  // Loading the live input while in reset means a level held through reset
  // looks unchanged once reset drops.
  always_comb begin
    hist_d = rst ? d : s1_q;
  end

  always_ff @(posedge clk) begin
    s1_q   <= d;
    hist_q <= hist_d;
  end

  assign pulse = ANY_EDGE ? (s1_q ^ hist_q) : (s1_q & ~hist_q);

endmodule

// File: rtl/host_ctrl_frontend.sv
// Host control front end: write strobes for core/ISA memory, run start
// pulse, saturating run timer, sticky done flags and registered status.
module host_ctrl_frontend
  import host_ctrl_frontend_pkg::*;
#(
  parameter int HOST_W     = 32,
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 10,
  parameter int ISA_ADDR_W = 6,
  parameter int NUM_DONE   = 11,
  parameter int CNT_W      = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HOST_W-1:0]     ctrl_lo,
  input  logic [HOST_W-1:0]     ctrl_hi,
  input  logic [DATA_W-1:0]     din,
  input  logic [NUM_DONE-1:0]   done_unit,
  input  logic                  done_all,
  output logic [ADDR_W-1:0]     core_addr,
  output logic [DATA_W-1:0]     core_din,
  output logic                  core_we,
  output logic [ISA_ADDR_W-1:0] isa_addr,
  output logic                  isa_we,
  output logic                  isa_start,
  output logic [HOST_W-1:0]     status
);

  localparam int TOG_BIT = ADDR_W + LO_TOGGLE_OFS;
  localparam int TGT_BIT = ADDR_W + LO_TARGET_OFS;

  logic [ADDR_W-1:0]   addr_s1_q;
  logic                tgt_s1_q;
  logic                sel_s1_q;
  logic [DATA_W-1:0]   din_s1_q;

  logic                tog_pulse;
  logic                start_pulse;
  logic                clr_pulse;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_DONE-1:0] sticky_q, sticky_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                core_we_q, core_we_d;
  logic                isa_we_q, isa_we_d;
  logic                isa_start_q, isa_start_d;
  logic [HOST_W-1:0]   status_q, status_d;

  logic                unused_ctrl_bits;
  assign unused_ctrl_bits = ^{ctrl_lo[HOST_W-1:TGT_BIT+1], ctrl_hi[HOST_W-1:HI_SEL_BIT+1],
                              ctrl_hi[0]};

  // S1 capture runs through reset as well, so it tracks the live inputs.
  always_ff @(posedge clk) begin
    addr_s1_q <= ctrl_lo[ADDR_W-1:0];
    tgt_s1_q  <= ctrl_lo[TGT_BIT];
    sel_s1_q  <= ctrl_hi[HI_SEL_BIT];
    din_s1_q  <= din;
  end

  host_ctrl_frontend_edge_pulse #(.ANY_EDGE(1'b1)) u_tog_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (ctrl_lo[TOG_BIT]),
    .pulse (tog_pulse)
  );

  host_ctrl_frontend_edge_pulse #(.ANY_EDGE(1'b0)) u_start_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (ctrl_hi[HI_START_BIT]),
    .pulse (start_pulse)
  );

  host_ctrl_frontend_edge_pulse #(.ANY_EDGE(1'b0)) u_clr_edge (
    .clk   (clk),
    .rst   (rst),
    .d     (ctrl_hi[HI_CLR_BIT]),
    .pulse (clr_pulse)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    isa_start_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_pulse) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          isa_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        // The done cycle itself is not counted.
        if (done_all) begin
          state_d = ST_DONE;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = ST_IDLE;
    endcase

    core_we_d = tog_pulse & (tgt_s1_q == TGT_CORE);
    isa_we_d  = tog_pulse & (tgt_s1_q == TGT_ISA);
    addr_d    = tog_pulse ? addr_s1_q : addr_q;
    din_d     = tog_pulse ? din_s1_q : din_q;

    // Clear first, then OR in new sets so a coincident set survives.
    sticky_d = (clr_pulse ? '0 : sticky_q) | done_unit;
    err_d    = (clr_pulse ? 1'b0 : err_q) | (tog_pulse & (state_q == ST_RUN));

    status_d = '0;
    if (sel_s1_q == SEL_COUNT) begin
      status_d[CNT_W:1] = cnt_q;
      status_d[0]       = (state_q == ST_DONE);
    end else begin
      status_d[NUM_DONE-1:0] = sticky_q;
      status_d[NUM_DONE]     = (state_q == ST_RUN);
      status_d[NUM_DONE+1]   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sticky_q    <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      core_we_q   <= 1'b0;
      isa_we_q    <= 1'b0;
      isa_start_q <= 1'b0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      core_we_q   <= core_we_d;
      isa_we_q    <= isa_we_d;
      isa_start_q <= isa_start_d;
      status_q    <= status_d;
    end
  end

  assign core_addr = addr_q;
  assign core_din  = din_q;
  assign core_we   = core_we_q;
  assign isa_addr  = addr_q[ISA_ADDR_W-1:0];
  assign isa_we    = isa_we_q;
  assign isa_start = isa_start_q;
  assign status    = status_q;

endmodule
